// File: rtl/banco_registros_sync.sv
// Clocked MIPS-32 register file: one synchronous write port, NRD read ports,
// optional write-to-read bypass, optional hardwired zero register, optional
// registered read outputs, and a wrapping count of accepted writes.
module banco_registros_sync #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned READ_REG = 0,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NRD*AW-1:0] Read_Reg,
    input  logic [NRD-1:0]    Read_En,
    input  logic [AW-1:0]     Write_Reg,
    input  logic [DW-1:0]     Write_Data,
    input  logic              RegWrite,
    output logic [NRD*DW-1:0] Read_data,
    output logic [15:0]       Wr_Count
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0]     regs_q [Depth];
    logic [DW-1:0]     regs_d [Depth];
    logic [15:0]       wr_count_q, wr_count_d;
    logic              wr_acc;
    logic [NRD*DW-1:0] rd_val;

    // A write is accepted only outside reset and never to a hardwired zero register.
    always_comb begin
        wr_acc = RegWrite && Rst_n && !((ZERO_REG != 0) && (Write_Reg == '0));
    end

    // Next state of the storage array and the write counter.
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_acc) begin
            regs_d[Write_Reg] = Write_Data;
            wr_count_d        = wr_count_q + 16'd1;
        end
    end

    // Storage and counter state, cleared asynchronously.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Per-port read value: zero register first, then bypass, then stored entry.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NRD; k++) begin
            if ((ZERO_REG != 0) && (Read_Reg[k*AW +: AW] == '0)) begin
                rd_val[k*DW +: DW] = '0;
            end else if ((BYPASS != 0) && wr_acc && (Write_Reg == Read_Reg[k*AW +: AW])) begin
                rd_val[k*DW +: DW] = Write_Data;
            end else begin
                rd_val[k*DW +: DW] = regs_q[Read_Reg[k*AW +: AW]];
            end
        end
    end

    assign Wr_Count = wr_count_q;

    if (READ_REG != 0) begin : g_rd_reg
        logic [NRD*DW-1:0] rd_q, rd_d;

        // Enabled ports capture their read value; disabled ports hold.
        always_comb begin
            rd_d = rd_q;
            for (int k = 0; k < NRD; k++) begin
                if (Read_En[k]) begin
                    rd_d[k*DW +: DW] = rd_val[k*DW +: DW];
                end
            end
        end

        // Registered read outputs for the pipelined core.
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign Read_data = rd_q;
    end else begin : g_rd_comb
        // Read enables only matter for registered outputs.
        logic unused_read_en;
        assign unused_read_en = ^Read_En;
        assign Read_data      = rd_val;
    end

endmodule
